// File: rtl/exception_controller_pkg.sv
// Shared CP0 constants and helpers for the prioritised exception controller.
package exc_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int unsigned STATUS_IE_BIT  = 0;
  localparam int unsigned STATUS_IM_LSB  = 8;
  localparam int unsigned CAUSE_IP_LSB   = 8;
  localparam int unsigned CAUSE_PRIO_LSB = 2;

  // Priority level is (source id + 1) in a 5-bit Cause field, capping sources at 31.
  localparam int unsigned PRIO_W  = 5;
  localparam int unsigned MAX_SRC = 31;

  typedef struct packed {
    logic              valid;
    logic [PRIO_W-1:0] idx;
  } prio_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic prio_t prio_enc(input logic [MAX_SRC-1:0] req);
    prio_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = PRIO_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/exception_controller_if.sv
// Datapath-facing bundle of the exception controller: retire/eret, CP0 access, PC redirects.
interface exception_controller_if #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned NEST_DEPTH = 3,
  parameter int unsigned ADDR_W     = 32
);
  import exc_pkg::*;

  localparam int unsigned NL_W = clog2(NEST_DEPTH + 1);

  logic [NUM_SRC-1:0] ExpSrc;
  logic               inst_retire;
  logic [ADDR_W-1:0]  pc_next;
  logic               eret;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic               exp_take;
  logic [ADDR_W-1:0]  exp_vector;
  logic               ret_take;
  logic [ADDR_W-1:0]  ret_pc;
  logic [NL_W-1:0]    nest_level;
  logic               eret_err;

  modport slave (
    input  ExpSrc, inst_retire, pc_next, eret, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, exp_take, exp_vector, ret_take, ret_pc, nest_level, eret_err
  );

  modport master (
    output ExpSrc, inst_retire, pc_next, eret, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, exp_take, exp_vector, ret_take, ret_pc, nest_level, eret_err
  );

endinterface

// File: rtl/exception_controller_epc_stack.sv
// LIFO of {EPC, saved priority} used for nested exception handling.
module exc_epc_stack
  import exc_pkg::*;
#(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned P_W     = 5,
  parameter int unsigned CNT_W   = clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_epc_i,
  input  logic [P_W-1:0]    push_prio_i,
  input  logic              top_we_i,
  input  logic [ADDR_W-1:0] top_epc_i,
  output logic [ADDR_W-1:0] top_epc_o,
  output logic [P_W-1:0]    top_prio_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] epc_q  [DEPTH];
  logic [P_W-1:0]    prio_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;

  assign full_o  = (32'(cnt_q) == DEPTH);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_comb begin
    top_epc_o  = '0;
    top_prio_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i == 32'(cnt_q) - 1) begin
        top_epc_o  = epc_q[i];
        top_prio_o = prio_q[i];
      end
    end
  end

  // A top-entry write loses to a push or pop landing on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        epc_q[i]  <= '0;
        prio_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 32'(cnt_q)) begin
          epc_q[i]  <= push_epc_i;
          prio_q[i] <= push_prio_i;
        end
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (top_we_i && !empty_o) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 32'(cnt_q) - 1) epc_q[i] <= top_epc_i;
      end
    end
  end

endmodule

// File: rtl/exception_controller.sv
// N-source prioritised exception controller with edge-latched pending bits and nested EPC stack.
module exception_controller
  import exc_pkg::*;
#(
  parameter int unsigned        NUM_SRC    = 3,
  parameter int unsigned        NEST_DEPTH = 3,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(32'h0000_0800),
  parameter logic [ADDR_W-1:0]  VEC_STRIDE = ADDR_W'(32'h0000_0010)
) (
  input logic                  Clock,
  input logic                  Reset_n,
  exception_controller_if.slave bus
);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d, clr_mask;
  logic               ie_q, ie_d;
  logic [NUM_SRC-1:0] im_q, im_d;
  logic [PRIO_W-1:0]  cur_prio_q, cur_prio_d, cand_lvl, top_prio;
  logic               eret_err_q, eret_err_d;
  prio_t              cand;
  logic               eligible, full, empty, epc_we;
  logic [ADDR_W-1:0]  top_epc;
  logic [31:0]        rdata;

  assign rise     = sync2_q & ~prev_q;
  assign cand     = prio_enc(MAX_SRC'(pending_q & im_q));
  assign cand_lvl = cand.idx + PRIO_W'(1);
  assign eligible = ie_q & cand.valid & (cand_lvl > cur_prio_q) & ~full;

  // eret has precedence; a blocked exception is re-evaluated after the pop.
  assign bus.exp_take   = bus.inst_retire & ~bus.eret & eligible;
  assign bus.ret_take   = bus.inst_retire & bus.eret & ~empty;
  assign bus.exp_vector = VEC_BASE + ADDR_W'(cand.idx) * VEC_STRIDE;
  assign bus.ret_pc     = top_epc;
  assign bus.eret_err   = eret_err_q;
  assign bus.cp0_rdata  = rdata;
  assign epc_we         = bus.cp0_we & (bus.cp0_addr == CP0_EPC) & ~empty;

  always_comb begin
    clr_mask   = '0;
    cur_prio_d = cur_prio_q;
    ie_d       = ie_q;
    im_d       = im_q;
    if (bus.exp_take) begin
      clr_mask   = NUM_SRC'(1) << cand.idx;
      cur_prio_d = cand_lvl;
    end else if (bus.ret_take) begin
      cur_prio_d = top_prio;
    end
    // A fresh edge on the source being taken keeps it pending.
    pending_d  = (pending_q & ~clr_mask) | rise;
    eret_err_d = eret_err_q | (bus.inst_retire & bus.eret & empty);
    if (bus.cp0_we && bus.cp0_addr == CP0_STATUS) begin
      ie_d = bus.cp0_wdata[STATUS_IE_BIT];
      im_d = bus.cp0_wdata[STATUS_IM_LSB +: NUM_SRC];
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cp0_addr)
      CP0_STATUS: begin
        rdata[STATUS_IE_BIT]           = ie_q;
        rdata[STATUS_IM_LSB +: NUM_SRC] = im_q;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_IP_LSB +: NUM_SRC]  = pending_q;
        rdata[CAUSE_PRIO_LSB +: PRIO_W] = cur_prio_q;
      end
      CP0_EPC: begin
        if (!empty) rdata = 32'(top_epc);
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      ie_q       <= 1'b1;
      im_q       <= '1;
      cur_prio_q <= '0;
      eret_err_q <= 1'b0;
    end else begin
      sync1_q    <= bus.ExpSrc;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      pending_q  <= pending_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      cur_prio_q <= cur_prio_d;
      eret_err_q <= eret_err_d;
    end
  end

  exc_epc_stack #(
    .DEPTH  (NEST_DEPTH),
    .ADDR_W (ADDR_W),
    .P_W    (PRIO_W)
  ) u_stack (
    .clk_i       (Clock),
    .rst_ni      (Reset_n),
    .push_i      (bus.exp_take),
    .pop_i       (bus.ret_take),
    .push_epc_i  (bus.pc_next),
    .push_prio_i (cur_prio_q),
    .top_we_i    (epc_we),
    .top_epc_i   (ADDR_W'(bus.cp0_wdata)),
    .top_epc_o   (top_epc),
    .top_prio_o  (top_prio),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (bus.nest_level)
  );

endmodule

// File: tb/tb_exception_controller.sv
// Scoreboard bench: two controllers (nest depth 3 and 1) share stimulus and are checked against a reference model.
module tb_exception_controller;
  import exc_pkg::*;

  bit   clk = 1'b0;
  logic rst_n;

  exception_controller_if #(.NUM_SRC(3), .NEST_DEPTH(3), .ADDR_W(32)) ifa ();
  exception_controller_if #(.NUM_SRC(3), .NEST_DEPTH(1), .ADDR_W(32)) ifb ();

  assign ifb.ExpSrc      = ifa.ExpSrc;
  assign ifb.inst_retire = ifa.inst_retire;
  assign ifb.pc_next     = ifa.pc_next;
  assign ifb.eret        = ifa.eret;
  assign ifb.cp0_we      = ifa.cp0_we;
  assign ifb.cp0_addr    = ifa.cp0_addr;
  assign ifb.cp0_wdata   = ifa.cp0_wdata;

  exception_controller #(.NUM_SRC(3), .NEST_DEPTH(3), .ADDR_W(32),
                         .VEC_BASE(32'h800), .VEC_STRIDE(32'h10))
    dut_a (.Clock(clk), .Reset_n(rst_n), .bus(ifa));

  exception_controller #(.NUM_SRC(3), .NEST_DEPTH(1), .ADDR_W(32),
                         .VEC_BASE(32'h800), .VEC_STRIDE(32'h10))
    dut_b (.Clock(clk), .Reset_n(rst_n), .bus(ifb));

  initial forever #5 clk = ~clk;

  typedef struct {
    bit        et;
    bit        rt;
    bit [31:0] vec;
    bit [31:0] rpc;
    bit [31:0] rdata;
    int        nest;
    bit        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   done = 0;

  // Reference model state: last three sampled ExpSrc values and per-DUT architectural state.
  bit [2:0]  h0, h1, h2;
  bit [2:0]  pend  [2];
  bit        ie    [2];
  bit [2:0]  im    [2];
  bit [31:0] spc   [2][4];
  int        sprio [2][4];
  int        cnt   [2];
  int        cur   [2];
  bit        err   [2];
  bit [2:0]  lvl;

  function automatic int depth(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; ie[d] = 1; im[d] = 3'b111;
      cnt[d] = 0; cur[d] = 0; err[d] = 0;
    end
  endtask

  task automatic step(input bit rst, input bit [2:0] src, input bit ret, input bit [31:0] pc,
                      input bit er, input bit we, input bit [4:0] a, input bit [31:0] wd);
    bit [2:0] rise;
    @(negedge clk);
    rst_n           = !rst;
    ifa.ExpSrc      = src;
    ifa.inst_retire = ret;
    ifa.pc_next     = pc;
    ifa.eret        = er;
    ifa.cp0_we      = we;
    ifa.cp0_addr    = a;
    ifa.cp0_wdata   = wd;
    if (rst) model_reset();
    rise = h1 & ~h2;
    for (int d = 0; d < 2; d++) begin
      exp_t     e;
      int       cand;
      bit       elig;
      bit [2:0] np;
      int       c0;
      cand = -1;
      for (int i = 2; i >= 0; i--)
        if (cand < 0 && pend[d][i] && im[d][i]) cand = i;
      elig   = ie[d] && cand >= 0 && cand + 1 > cur[d] && cnt[d] < depth(d);
      e.et   = ret && !er && elig;
      e.rt   = ret && er && cnt[d] > 0;
      e.vec  = 32'h800 + 32'(cand) * 32'h10;
      e.rpc  = (cnt[d] > 0) ? spc[d][cnt[d]-1] : 32'h0;
      case (a)
        5'd12:   e.rdata = (32'(im[d]) << 8) | 32'(ie[d]);
        5'd13:   e.rdata = (32'(pend[d]) << 8) | (32'(cur[d]) << 2);
        5'd14:   e.rdata = (cnt[d] > 0) ? spc[d][cnt[d]-1] : 32'h0;
        default: e.rdata = 32'h0;
      endcase
      e.nest = cnt[d];
      e.err  = err[d];
      if (d == 0) qa.push_back(e); else qb.push_back(e);
      if (!rst) begin
        c0 = cnt[d];
        np = pend[d];
        if (e.et) begin
          np[cand] = 1'b0;
          spc[d][cnt[d]] = pc; sprio[d][cnt[d]] = cur[d];
          cnt[d]++; cur[d] = cand + 1;
        end else if (e.rt) begin
          cnt[d]--; cur[d] = sprio[d][cnt[d]];
        end else if (we && a == 5'd14 && cnt[d] > 0) begin
          spc[d][cnt[d]-1] = wd;
        end
        pend[d] = np | rise;
        if (ret && er && c0 == 0) err[d] = 1'b1;
        if (we && a == 5'd12) begin
          ie[d] = wd[0]; im[d] = wd[10:8];
        end
      end
    end
    if (!rst) begin
      h2 = h1; h1 = h0; h0 = src;
    end
  endtask

  function automatic bit [4:0] raddr();
    case ($urandom_range(0, 3))
      0:       return 5'd12;
      1:       return 5'd13;
      2:       return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) step(0, lvl, 0, 0, 0, 0, raddr(), 0);
  endtask
  task automatic pulse(input bit [2:0] s);
    lvl = s; idle(1); lvl = 0; idle(3);
  endtask
  task automatic retire(input bit [31:0] pc);
    step(0, lvl, 1, pc, 0, 0, raddr(), 0);
  endtask
  task automatic eret_r();
    step(0, lvl, 1, 32'h0000_0100, 1, 0, raddr(), 0);
  endtask
  task automatic mtc0(input bit [4:0] a, input bit [31:0] wd);
    step(0, lvl, 0, 0, 0, 1, a, wd);
  endtask
  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 5'd12, 0);
    step(1, 0, 0, 0, 0, 0, 5'd13, 0);
  endtask

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected response per cycle and compares both controllers.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      #2;
      if (qa.size() == 0 || qb.size() == 0) begin
        if (!done) begin
          nvec++; nerr++;
          $display("FAIL scoreboard_empty actual=0 required=1");
        end
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_exp_take", 32'(ifa.exp_take), 32'(ea.et));
        chk("a_ret_take", 32'(ifa.ret_take), 32'(ea.rt));
        chk("a_cp0_rdata", ifa.cp0_rdata, ea.rdata);
        chk("a_nest_level", 32'(ifa.nest_level), 32'(ea.nest));
        chk("a_eret_err", 32'(ifa.eret_err), 32'(ea.err));
        if (ea.et) chk("a_exp_vector", ifa.exp_vector, ea.vec);
        if (ea.rt) chk("a_ret_pc", ifa.ret_pc, ea.rpc);
        chk("b_exp_take", 32'(ifb.exp_take), 32'(eb.et));
        chk("b_ret_take", 32'(ifb.ret_take), 32'(eb.rt));
        chk("b_cp0_rdata", ifb.cp0_rdata, eb.rdata);
        chk("b_nest_level", 32'(ifb.nest_level), 32'(eb.nest));
        chk("b_eret_err", 32'(ifb.eret_err), 32'(eb.err));
        if (eb.et) chk("b_exp_vector", ifb.exp_vector, eb.vec);
        if (eb.rt) chk("b_ret_pc", ifb.ret_pc, eb.rpc);
      end
    end
  end

  initial begin
    bit        ret, er, we;
    bit [4:0]  a;
    bit [31:0] wd;
    rst_n = 1'b0;
    ifa.ExpSrc = 0; ifa.inst_retire = 0; ifa.pc_next = 0; ifa.eret = 0;
    ifa.cp0_we = 0; ifa.cp0_addr = 5'd12; ifa.cp0_wdata = 0;
    lvl = 0;
    model_reset();
    do_reset();
    idle(2);
    // single take and return
    pulse(3'b001); retire(32'h40); idle(1); eret_r(); idle(1);
    // nesting and priority
    pulse(3'b001); retire(32'h40); pulse(3'b100); retire(32'h44);
    pulse(3'b010); retire(32'h48); retire(32'h4c); eret_r(); retire(32'h50);
    eret_r(); eret_r(); retire(32'h54); eret_r(); eret_r();
    // simultaneous sources
    pulse(3'b101); retire(32'h60); eret_r(); retire(32'h64); eret_r();
    // masking
    mtc0(5'd12, 32'h301); pulse(3'b100); retire(32'h70); retire(32'h74);
    mtc0(5'd12, 32'h701); retire(32'h78); mtc0(5'd14, 32'h1234); idle(1); eret_r();
    // same-source edge on the take cycle
    pulse(3'b001); lvl = 3'b001; idle(2); retire(32'h90); lvl = 0; idle(1);
    eret_r(); retire(32'h94); idle(1);
    // reset mid-handler
    do_reset(); idle(2);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) lvl = 3'($urandom);
      ret = ($urandom_range(0, 1) == 1);
      er  = ret && ($urandom_range(0, 2) == 0);
      we  = ($urandom_range(0, 9) == 0);
      a   = we ? 5'(12 + $urandom_range(0, 2)) : raddr();
      wd  = $urandom;
      if (a == 5'd12 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if (a == 5'd12 && $urandom_range(0, 1) == 1) wd[10:8] = 3'b111;
      step(0, lvl, ret, $urandom & 32'hffff_fffc, er, we, a, wd);
    end
    done = 1;
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Parametrised successor to the fixed 3-source CP0 exception path.
- Adds N prioritised exception sources with a per-source mask, edge-latched pending bits, and nested handling through an EPC stack.
- Sits beside the datapath. On each instruction retire it decides whether to redirect the PC to a per-source vector or to return from a handler (eret).
- Exposes Status/Cause/EPC to mfc0/mtc0.

Parameters:
NUM_SRC, 3, number of exception sources; index NUM_SRC-1 has highest priority
NEST_DEPTH, 3, EPC stack entries (max nesting level)
ADDR_W, 32, PC width
VEC_BASE, 32'h00000800, vector of source 0
VEC_STRIDE, 32'h00000010, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
ExpSrc  in  NUM_SRC  asynchronous exception request lines (button/level)
inst_retire  in  1  current instruction completes this cycle
pc_next  in  ADDR_W  PC the CPU would load absent an exception
eret  in  1  retiring instruction is eret
cp0_we  in  1  mtc0 write strobe
cp0_addr  in  5  CP0 register number
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational
exp_take  out  1  redirect PC to exp_vector this cycle, combinational
exp_vector  out  ADDR_W  handler address
ret_take  out  1  redirect PC to ret_pc this cycle, combinational
ret_pc  out  ADDR_W  top-of-stack EPC
nest_level  out  clog2(NEST_DEPTH+1)  stack occupancy
eret_err  out  1  sticky: eret with empty stack

Behaviour:
- Reset (async, Reset_n=0):
  - sync/edge flops 0, pending 0, stack empty, nest_level 0, cur_prio 0, eret_err 0.
  - Status.IE=1, Status.IM all 1.
  - Outputs exp_take=0, ret_take=0.
- Reset mid-handler discards the whole stack.
- Input path, per source: 2-flop synchroniser plus a previous-value flop. A rising edge sets pending[i].
  - ExpSrc high before edge 0 gives pending visible after edge 2.
  - A level held high sets pending once only.
- Priority: cur_prio = 0 outside handlers, else (source id + 1) of the handler on top of the stack.
  - cand = highest i with pending[i] & IM[i].
  - eligible = IE & (cand exists) & (cand+1 > cur_prio) & (nest_level < NEST_DEPTH).
- exp_take = inst_retire & ~eret & eligible.
  - On that clock edge: push {pc_next, cur_prio}, clear pending[cand], cur_prio <= cand+1.
  - exp_vector = VEC_BASE + cand*VEC_STRIDE.
- ret_take = inst_retire & eret & (nest_level != 0).
  - ret_pc = top EPC. On the edge: pop and restore cur_prio.
- eret with an empty stack: ret_take=0, eret_err <= 1 (cleared only by reset).
- Simultaneous eret and eligible exception: eret wins. The exception is re-evaluated at the next retire against the popped level.
- Same-source new edge on the same cycle that source is taken: set wins, and pending stays 1.
- Stack full: no take, pending is retained.
- Lower-or-equal priority pending source: held until an eret lowers cur_prio.
- CP0 map:
  - reg 12 Status: bit0 IE, bits[8+NUM_SRC-1:8] IM, others read 0; writable.
  - reg 13 Cause: bits[8+NUM_SRC-1:8] pending, bits[6:2] cur_prio; read-only, writes ignored.
  - reg 14 EPC: top-of-stack EPC, reads 0 when empty. A write overwrites the top entry; ignored when empty.
  - Other addresses read 0.
- mtc0 Status takes effect for decisions in the following cycle.

Decomposition:
- Package exc_pkg:
  - CP0 register numbers (12/13/14)
  - Status/Cause bit positions
  - priority-encoder function (highest set index plus valid)
  - clog2 helper
- Sub-module exc_epc_stack:
  - parametrised LIFO of {ADDR_W-bit EPC, prio}
  - push/pop/top-write ports, full/empty/count
  - push and pop never asserted together.

Test Plan:
1. Reset: read reg 12 -> 0x00000701 (NUM_SRC=3); reg 13 -> 0; nest_level 0; exp_take 0.
2. Single take and return: pulse ExpSrc[0]; 3 cycles later retire with pc_next=0x40 -> exp_take=1, exp_vector=0x800, nest_level 1, reg14=0x40. Then eret retire -> ret_take=1, ret_pc=0x40, nest_level 0.
3. Nesting and priority: in the src0 handler, raise src2 -> take at 0x820, nest_level 2. Raise src1 -> reg13 bit9=1, no take until eret of src2, then src1 is taken at 0x810.
4. Simultaneous sources: ExpSrc=3'b101 in one cycle -> src2 taken first. After its eret, src0 is taken.
5. Masking: mtc0 Status=0x00000301; pulse src2 -> Cause bit10=1, no take. Write 0x00000701 -> src2 taken at the next retire.
6. Depth and error: NEST_DEPTH=1, src0 active, src2 pending -> no take while full, taken after eret. eret at nest_level 0 -> ret_take=0, eret_err=1. Reset_n low mid-handler -> nest_level 0, eret_err 0.
